aes_ctr_sequencer: RTL
======================

// Module: aes_ctr_sequencer
// PURPOSE
//  CTR-mode controller for the AES-256 encryption core. Latches key/nonce/counter and block count,
//  drives counter blocks {nonce,ctr} into the core, waits the fixed core latency, captures keystream,
//  XORs it with streamed plaintext, emits ciphertext via valid/ready. Sits between the bus-side
//  stream and the encryption core instance; the core has no start/done, so this block times it.
// PARAMETERS
//  CORE_LATENCY  16  cycles core_block_o/core_key_o must be held stable before core_ks_i is valid (>=1)
//  NB_W          16  width of block-count input
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    asynchronous, active-low reset
//  start_i      in   1    start job (sampled only in IDLE)
//  key_i        in   256  AES-256 key, latched on start
//  nonce_i      in   96   CTR nonce, latched on start, never modified
//  ctr_init_i   in   32   initial counter, latched on start
//  nblocks_i    in   NB_W number of 128-bit blocks in job
//  busy_o       out  1    high from start acceptance until job end
//  done_o       out  1    one-cycle pulse at job end
//  pt_valid_i   in   1    plaintext valid
//  pt_ready_o   out  1    plaintext ready
//  pt_data_i    in   128  plaintext block
//  ct_valid_o   out  1    ciphertext valid
//  ct_ready_i   in   1    ciphertext ready
//  ct_data_o    out  128  ciphertext block
//  core_block_o out  128  counter block to core plaintext input
//  core_key_o   out  256  key to core
//  core_ks_i    in   128  core ciphertext output (keystream)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy_o, done_o, pt_ready_o, ct_valid_o = 0; ct_data_o,
//   core_block_o, core_key_o, internal ctr/remaining/wait count/ks reg = 0.
//  All outputs registered or decoded from state only; no combinational path from inputs to outputs.
//  FSM: IDLE -> KS -> WAIT_PT -> OUT -> (KS | IDLE).
//  IDLE: start_i=1 latches key, nonce, ctr_init, nblocks. nblocks=0 -> done_o pulse next cycle,
//   stay IDLE, busy_o stays 0. Else -> KS, busy_o=1 next cycle.
//  KS: core_block_o={nonce,ctr}, core_key_o=key, held constant; wait count 0..CORE_LATENCY-1;
//   in the cycle count==CORE_LATENCY-1, ks_reg<=core_ks_i, -> WAIT_PT.
//  WAIT_PT: pt_ready_o=1. On pt_valid_i&pt_ready_o: ct_data_o<=pt_data_i^ks_reg, ct_valid_o<=1, -> OUT.
//  OUT: ct_valid_o and ct_data_o held stable until ct_ready_i=1 (backpressure for any duration).
//   On handshake: ct_valid_o<=0, ctr<=ctr+1 (mod 2^32, nonce untouched), remaining<=remaining-1;
//   remaining was 1 -> done_o pulse, busy_o<=0, -> IDLE; else -> KS (new wait window).
//  Latency: start accepted at edge N -> pt_ready_o first high at edge N+1+CORE_LATENCY.
//  Per block: CORE_LATENCY + 2 cycles minimum (zero stall on both streams).
//  Counter wrap: ctr=FFFFFFFF -> next block uses 00000000; no flag, no nonce carry.
//  start_i while busy: ignored; latched key/nonce unaffected by input changes mid-job.
//  pt_valid_i outside WAIT_PT: ignored (pt_ready_o=0, no data consumed).
//  Reset mid-job: immediate return to reset state; partial block discarded, no done_o.
// TESTING
//  1 FIPS-197 vector: key=000102..1f, nonce=00112233445566778899aabb, ctr=ccddeeff, nblocks=1,
//    pt=0 -> ct=8ea2b7ca516745bfeafc49904b496089, done_o one pulse, busy_o low after.
//  2 nblocks=3, ctr=00000005, random pt: core_block_o low word 5,6,7; ct_i=pt_i^AES(key,{nonce,ctr_i}).
//  3 ctr_init=FFFFFFFF, nblocks=2 -> second core_block_o={nonce,00000000}, nonce bits unchanged.
//  4 ct_ready_i held low 20 cycles in OUT -> ct_valid_o/ct_data_o stable, no ctr advance;
//    pt_valid_i low 10 cycles in WAIT_PT -> no state change.
//  5 nblocks=0 -> done_o pulse next cycle, busy_o never high, no pt_ready_o;
//    start_i pulsed mid-job -> ignored, job count unchanged.
//  6 rst low mid-KS of block 2 -> all outputs 0 asynchronously; fresh start then gives correct vector 1.

Source files
------------

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer for an AES-256 core that has no start/done handshake.
// Latches the job parameters, presents {nonce,ctr} to the core, times the fixed
// core latency, captures the keystream and XORs it with the plaintext stream.
//
// state   | meaning
// IDLE    | no job; start_i sampled here
// KS      | counter block held on the core, waiting out CORE_LATENCY
// WAIT_PT | keystream captured, pt_ready_o high, waiting for plaintext
// OUT     | ciphertext valid, held until ct_ready_i
module aes_ctr_sequencer #(
    parameter int CORE_LATENCY = 16,
    parameter int NB_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [255:0]    key_i,
    input  logic [95:0]     nonce_i,
    input  logic [31:0]     ctr_init_i,
    input  logic [NB_W-1:0] nblocks_i,
    output logic            busy_o,
    output logic            done_o,
    input  logic            pt_valid_i,
    output logic            pt_ready_o,
    input  logic [127:0]    pt_data_i,
    output logic            ct_valid_o,
    input  logic            ct_ready_i,
    output logic [127:0]    ct_data_o,
    output logic [127:0]    core_block_o,
    output logic [255:0]    core_key_o,
    input  logic [127:0]    core_ks_i
);

    typedef enum logic [1:0] {IDLE, KS, WAIT_PT, OUT} state_t;

    localparam int CW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(CORE_LATENCY - 1);

    state_t          state_q, state_d;
    logic [255:0]    key_q;
    logic [95:0]     nonce_q;
    logic [31:0]     ctr_q;
    logic [NB_W-1:0] rem_q;
    logic [CW-1:0]   wait_q;
    logic [127:0]    ks_q;
    // First block of a job spends one cycle loading core_block_o from the
    // freshly latched nonce/ctr before the latency window starts counting.
    logic            load_pend_q;

    assign core_key_o = key_q;
    assign pt_ready_o = (state_q == WAIT_PT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i && (nblocks_i != '0)) begin
                    state_d = KS;
                end
            end
            KS: begin
                if (!load_pend_q && (wait_q == WAIT_LAST)) begin
                    state_d = WAIT_PT;
                end
            end
            WAIT_PT: begin
                if (pt_valid_i) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (ct_ready_i) begin
                    state_d = (rem_q == NB_W'(1)) ? IDLE : KS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job registers, latency timer, keystream capture and output stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q        <= '0;
            nonce_q      <= '0;
            ctr_q        <= '0;
            rem_q        <= '0;
            wait_q       <= '0;
            ks_q         <= '0;
            load_pend_q  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            ct_valid_o   <= 1'b0;
            ct_data_o    <= '0;
            core_block_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        key_q   <= key_i;
                        nonce_q <= nonce_i;
                        ctr_q   <= ctr_init_i;
                        rem_q   <= nblocks_i;
                        wait_q  <= '0;
                        if (nblocks_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            busy_o      <= 1'b1;
                            load_pend_q <= 1'b1;
                        end
                    end
                end
                KS: begin
                    if (load_pend_q) begin
                        core_block_o <= {nonce_q, ctr_q};
                        load_pend_q  <= 1'b0;
                    end else if (wait_q == WAIT_LAST) begin
                        ks_q   <= core_ks_i;
                        wait_q <= '0;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                WAIT_PT: begin
                    if (pt_valid_i) begin
                        ct_data_o  <= pt_data_i ^ ks_q;
                        ct_valid_o <= 1'b1;
                    end
                end
                OUT: begin
                    if (ct_ready_i) begin
                        ct_valid_o   <= 1'b0;
                        ctr_q        <= ctr_q + 32'd1;
                        // Next counter block goes straight to the core so the
                        // following latency window starts this cycle.
                        core_block_o <= {nonce_q, ctr_q + 32'd1};
                        rem_q        <= rem_q - NB_W'(1);
                        if (rem_q == NB_W'(1)) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
